// File: rtl/core_axi_pkg.sv
// Shared AXI4 constants and arbiter types for the core's single memory master port.
package core_axi_pkg;

    localparam int ADDR_W = 29;
    localparam int DATA_W = 512;
    localparam int WORD_W = 32;
    localparam int STRB_W = DATA_W / 8;
    localparam int LANES  = DATA_W / WORD_W;

    localparam logic [7:0] AXI_LEN   = 8'd0;
    localparam logic [2:0] AXI_SIZE  = 3'b010;
    localparam logic [1:0] AXI_BURST = 2'b00;
    localparam logic [3:0] AXI_CACHE = 4'b0011;
    localparam logic [3:0] AXI_ID    = 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        RADDR,
        RDATA,
        WRITE,
        WRESP
    } arb_state_t;

    typedef enum logic {
        REQ_IF,
        REQ_EX
    } req_id_t;

endpackage

// File: rtl/axi_lane.sv
// Maps a 32-bit word onto one lane of the 512-bit AXI bus selected by addr[5:2].
module axi_lane
    import core_axi_pkg::*;
(
    input  logic [3:0]        lane,
    input  logic [DATA_W-1:0] rdata,
    input  logic [WORD_W-1:0] wword,
    input  logic [3:0]        wbe,
    output logic [WORD_W-1:0] rword,
    output logic [DATA_W-1:0] wline,
    output logic [STRB_W-1:0] wstrb
);

    assign rword = rdata[{lane, 5'b00000} +: WORD_W];
    assign wline = {LANES{wword}};
    assign wstrb = {{(STRB_W-4){1'b0}}, wbe} << {lane, 2'b00};

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch and exec word requests onto one single-beat AXI4 master port.
// Define MEM_ARB_RR_EN for round-robin tie breaking; otherwise exec wins ties.
module mem_arbiter
    import core_axi_pkg::*;
(
    input  logic          clk,
    input  logic          rstn,
    input  logic          if_req,
    input  logic [28:0]   if_addr,
    output logic          if_done,
    output logic [31:0]   if_rdata,
    input  logic          ex_req,
    input  logic          ex_we,
    input  logic [28:0]   ex_addr,
    input  logic [31:0]   ex_wdata,
    input  logic [3:0]    ex_wbe,
    output logic          ex_done,
    output logic [31:0]   ex_rdata,
    output logic          resp_err,
    output logic [28:0]   araddr,
    output logic [1:0]    arburst,
    output logic [3:0]    arcache,
    output logic [3:0]    arid,
    output logic [7:0]    arlen,
    output logic          arlock,
    output logic [2:0]    arprot,
    output logic [3:0]    arqos,
    output logic [2:0]    arsize,
    output logic          arvalid,
    input  logic          arready,
    input  logic [511:0]  rdata,
    input  logic [3:0]    rid,
    input  logic          rlast,
    input  logic [1:0]    rresp,
    input  logic          rvalid,
    output logic          rready,
    output logic [28:0]   awaddr,
    output logic [1:0]    awburst,
    output logic [3:0]    awcache,
    output logic [3:0]    awid,
    output logic [7:0]    awlen,
    output logic          awlock,
    output logic [2:0]    awprot,
    output logic [3:0]    awqos,
    output logic [2:0]    awsize,
    output logic          awvalid,
    input  logic          awready,
    output logic [511:0]  wdata,
    output logic [63:0]   wstrb,
    output logic          wlast,
    output logic          wvalid,
    input  logic          wready,
    input  logic          bvalid,
    input  logic [3:0]    bid,
    input  logic [1:0]    bresp,
    output logic          bready
);

    assign arburst = AXI_BURST;
    assign arcache = AXI_CACHE;
    assign arid    = AXI_ID;
    assign arlen   = AXI_LEN;
    assign arlock  = 1'b0;
    assign arprot  = 3'b000;
    assign arqos   = 4'd0;
    assign arsize  = AXI_SIZE;
    assign awburst = AXI_BURST;
    assign awcache = AXI_CACHE;
    assign awid    = AXI_ID;
    assign awlen   = AXI_LEN;
    assign awlock  = 1'b0;
    assign awprot  = 3'b000;
    assign awqos   = 4'd0;
    assign awsize  = AXI_SIZE;

    logic unused_ids;
    assign unused_ids = ^{rid, bid};

    arb_state_t          state_q, state_d;
    req_id_t             gnt_q, gnt_d;
    logic [3:0]          lane_q, lane_d;
    logic                arvalid_d, rready_d, awvalid_d, wvalid_d, wlast_d, bready_d;
    logic [28:0]         araddr_d, awaddr_d;
    logic [DATA_W-1:0]   wdata_d;
    logic [STRB_W-1:0]   wstrb_d;
    logic                if_done_d, ex_done_d, resp_err_d;
    logic [WORD_W-1:0]   if_rdata_d, ex_rdata_d;

    logic [3:0]          lane_sel;
    logic [WORD_W-1:0]   lane_rword;
    logic [DATA_W-1:0]   lane_wline;
    logic [STRB_W-1:0]   lane_wstrb;

    // In IDLE the lane steers a fresh write grant; afterwards it reads back the latched one.
    assign lane_sel = (state_q == IDLE) ? ex_addr[5:2] : lane_q;

    axi_lane u_lane (
        .lane  (lane_sel),
        .rdata (rdata),
        .wword (ex_wdata),
        .wbe   (ex_wbe),
        .rword (lane_rword),
        .wline (lane_wline),
        .wstrb (lane_wstrb)
    );

    logic if_act, ex_act, tie_ex, pick_ex;

    // A requester whose done is showing this cycle is still holding a stale req.
    assign if_act  = if_req && !if_done;
    assign ex_act  = ex_req && !ex_done;
    assign pick_ex = ex_act && (!if_act || tie_ex);

`ifdef MEM_ARB_RR_EN
    req_id_t last_q, last_d;
    assign tie_ex = (last_q == REQ_IF);
`else
    assign tie_ex = 1'b1;
`endif

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        lane_d     = lane_q;
        arvalid_d  = arvalid;
        araddr_d   = araddr;
        rready_d   = rready;
        awvalid_d  = awvalid;
        awaddr_d   = awaddr;
        wvalid_d   = wvalid;
        wdata_d    = wdata;
        wstrb_d    = wstrb;
        wlast_d    = wlast;
        bready_d   = bready;
        if_done_d  = 1'b0;
        ex_done_d  = 1'b0;
        resp_err_d = 1'b0;
        if_rdata_d = if_rdata;
        ex_rdata_d = ex_rdata;
`ifdef MEM_ARB_RR_EN
        last_d     = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (if_act || ex_act) begin
                    gnt_d = pick_ex ? REQ_EX : REQ_IF;
`ifdef MEM_ARB_RR_EN
                    last_d = pick_ex ? REQ_EX : REQ_IF;
`endif
                    if (pick_ex && ex_we) begin
                        lane_d    = ex_addr[5:2];
                        awvalid_d = 1'b1;
                        awaddr_d  = ex_addr;
                        wvalid_d  = 1'b1;
                        wlast_d   = 1'b1;
                        wdata_d   = lane_wline;
                        wstrb_d   = lane_wstrb;
                        state_d   = WRITE;
                    end else begin
                        lane_d    = pick_ex ? ex_addr[5:2] : if_addr[5:2];
                        arvalid_d = 1'b1;
                        araddr_d  = pick_ex ? ex_addr : if_addr;
                        state_d   = RADDR;
                    end
                end
            end
            RADDR: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RDATA;
                end
            end
            RDATA: begin
                if (rvalid && rlast) begin
                    rready_d   = 1'b0;
                    resp_err_d = |rresp;
                    if (gnt_q == REQ_EX) begin
                        ex_done_d  = 1'b1;
                        ex_rdata_d = lane_rword;
                    end else begin
                        if_done_d  = 1'b1;
                        if_rdata_d = lane_rword;
                    end
                    state_d = IDLE;
                end
            end
            WRITE: begin
                if (awready) begin
                    awvalid_d = 1'b0;
                end
                if (wready) begin
                    wvalid_d = 1'b0;
                    wlast_d  = 1'b0;
                end
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = WRESP;
                end
            end
            WRESP: begin
                if (bvalid) begin
                    bready_d   = 1'b0;
                    ex_done_d  = 1'b1;
                    resp_err_d = |bresp;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            gnt_q    <= REQ_IF;
            lane_q   <= 4'd0;
            arvalid  <= 1'b0;
            araddr   <= '0;
            rready   <= 1'b0;
            awvalid  <= 1'b0;
            awaddr   <= '0;
            wvalid   <= 1'b0;
            wdata    <= '0;
            wstrb    <= '0;
            wlast    <= 1'b0;
            bready   <= 1'b0;
            if_done  <= 1'b0;
            ex_done  <= 1'b0;
            resp_err <= 1'b0;
            if_rdata <= '0;
            ex_rdata <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            lane_q   <= lane_d;
            arvalid  <= arvalid_d;
            araddr   <= araddr_d;
            rready   <= rready_d;
            awvalid  <= awvalid_d;
            awaddr   <= awaddr_d;
            wvalid   <= wvalid_d;
            wdata    <= wdata_d;
            wstrb    <= wstrb_d;
            wlast    <= wlast_d;
            bready   <= bready_d;
            if_done  <= if_done_d;
            ex_done  <= ex_done_d;
            resp_err <= resp_err_d;
            if_rdata <= if_rdata_d;
            ex_rdata <= ex_rdata_d;
        end
    end

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            last_q <= REQ_IF;
        end else begin
            last_q <= last_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests, an AXI slave model and a decoupled monitor.
module tb_mem_arbiter;

    logic          clk = 1'b0;
    logic          rstn;
    logic          if_req, if_done;
    logic [28:0]   if_addr;
    logic [31:0]   if_rdata;
    logic          ex_req, ex_we, ex_done, resp_err;
    logic [28:0]   ex_addr;
    logic [31:0]   ex_wdata, ex_rdata;
    logic [3:0]    ex_wbe;
    logic [28:0]   araddr, awaddr;
    logic [1:0]    arburst, awburst, rresp, bresp;
    logic [3:0]    arcache, arid, arqos, awcache, awid, awqos, rid, bid;
    logic [7:0]    arlen, awlen;
    logic          arlock, awlock, arvalid, arready, rlast, rvalid, rready;
    logic [2:0]    arprot, arsize, awprot, awsize;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [511:0]  rdata, wdata;
    logic [63:0]   wstrb;

    mem_arbiter dut (
        .clk(clk), .rstn(rstn),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .ex_req(ex_req), .ex_we(ex_we), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_wbe(ex_wbe),
        .ex_done(ex_done), .ex_rdata(ex_rdata), .resp_err(resp_err),
        .araddr(araddr), .arburst(arburst), .arcache(arcache), .arid(arid), .arlen(arlen),
        .arlock(arlock), .arprot(arprot), .arqos(arqos), .arsize(arsize), .arvalid(arvalid),
        .arready(arready),
        .rdata(rdata), .rid(rid), .rlast(rlast), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .awaddr(awaddr), .awburst(awburst), .awcache(awcache), .awid(awid), .awlen(awlen),
        .awlock(awlock), .awprot(awprot), .awqos(awqos), .awsize(awsize), .awvalid(awvalid),
        .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bvalid(bvalid), .bid(bid), .bresp(bresp), .bready(bready)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no done within cycle budget, expected done", name);
    endtask

    typedef struct {
        bit          is_ex;
        logic [31:0] rd;
        bit          err;
        bit          chk_rd;
    } done_t;

    typedef struct {
        logic [511:0] data;
        logic [63:0]  strb;
    } wexp_t;

    done_t       done_q[$];
    logic [28:0] ar_q[$];
    logic [28:0] aw_q[$];
    wexp_t       w_q[$];

    task automatic exp_done(input bit is_ex, input logic [31:0] rd, input bit err, input bit chk_rd);
        done_t e;
        e.is_ex = is_ex; e.rd = rd; e.err = err; e.chk_rd = chk_rd;
        done_q.push_back(e);
    endtask

    task automatic exp_write(input logic [28:0] a, input logic [511:0] d, input logic [63:0] s);
        wexp_t w;
        w.data = d; w.strb = s;
        aw_q.push_back(a);
        w_q.push_back(w);
    endtask

    // ---------------- AXI slave model ----------------
    int          ar_dly = 0, aw_dly = 0, w_dly = 0;
    logic [1:0]  rresp_cfg = 2'b00, bresp_cfg = 2'b00;
    bit          r_hold = 0;

    function automatic logic [511:0] gen_line(input logic [28:0] a);
        logic [511:0] l;
        for (int i = 0; i < 16; i++)
            l[i*32 +: 32] = 32'hB000_0000 | ({9'd0, a[28:6]} << 4) | 32'(i);
        if (a[28:6] == 23'd1) l[63:32] = 32'hDEADBEEF;
        return l;
    endfunction

    initial begin : slave
        bit          arhs, rhs, awhs, whs, bhs, pend_r, aw_got, w_got;
        logic [28:0] hs_addr, rd_addr;
        int          ar_cnt, aw_cnt, w_cnt;
        arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = 0; rid = 4'd0;
        awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = 4'd0;
        pend_r = 0; aw_got = 0; w_got = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0; rd_addr = '0;
        forever begin
            @(negedge clk);
            arhs = arvalid && arready; rhs = rvalid && rready;
            awhs = awvalid && awready; whs = wvalid && wready; bhs = bvalid && bready;
            hs_addr = araddr;
            @(posedge clk);
            #1;
            if (!rstn) begin
                arready = 0; rvalid = 0; rlast = 0; rdata = '0; rresp = 0;
                awready = 0; wready = 0; bvalid = 0; bresp = 0;
                pend_r = 0; aw_got = 0; w_got = 0; ar_cnt = 0; aw_cnt = 0; w_cnt = 0;
            end else begin
                if (rhs) begin rvalid = 0; rlast = 0; rdata = '0; rresp = 0; end
                if (arhs) begin arready = 0; ar_cnt = 0; rd_addr = hs_addr; pend_r = 1; end
                if (pend_r && !r_hold) begin
                    rvalid = 1; rlast = 1; rdata = gen_line(rd_addr); rresp = rresp_cfg; pend_r = 0;
                end
                if (arvalid && !arready) begin
                    if (ar_cnt >= ar_dly) arready = 1; else ar_cnt++;
                end
                if (bhs) begin bvalid = 0; bresp = 0; end
                if (awhs) begin awready = 0; aw_cnt = 0; aw_got = 1; end
                if (whs) begin wready = 0; w_cnt = 0; w_got = 1; end
                if (aw_got && w_got) begin bvalid = 1; bresp = bresp_cfg; aw_got = 0; w_got = 0; end
                if (awvalid && !awready) begin
                    if (aw_cnt >= aw_dly) awready = 1; else aw_cnt++;
                end
                if (wvalid && !wready) begin
                    if (w_cnt >= w_dly) wready = 1; else w_cnt++;
                end
            end
        end
    end

    // ---------------- monitor / scoreboard ----------------
    int           ar_cnt_seen = 0;
    int           bhs_cyc = 0;
    bit           w_first = 0;
    bit           ar_stall = 0, aw_stall = 0, w_stall = 0;
    logic [28:0]  ar_stall_addr, aw_stall_addr;
    logic [511:0] w_stall_data;
    logic [63:0]  w_stall_strb;
    done_t        mon_e;
    logic [28:0]  mon_a;
    wexp_t        mon_w;

    always @(negedge clk) begin
        if (!rstn) begin
            ar_stall = 0; aw_stall = 0; w_stall = 0;
        end else begin
            if (if_done || ex_done) begin
                if (done_q.size() == 0) begin
                    check("done_spurious", {ex_done, if_done}, 2'b00);
                end else begin
                    mon_e = done_q.pop_front();
                    check("done_src", {ex_done, if_done}, mon_e.is_ex ? 2'b10 : 2'b01);
                    if (mon_e.chk_rd)
                        check("rdata", mon_e.is_ex ? ex_rdata : if_rdata, mon_e.rd);
                    check("resp_err", resp_err, mon_e.err);
                end
            end else if (resp_err) begin
                check("resp_err_stray", resp_err, 1'b0);
            end
            if (arvalid && arready) begin
                ar_cnt_seen++;
                if (ar_q.size() == 0) check("ar_spurious", araddr, 29'h1FFF_FFFF);
                else begin mon_a = ar_q.pop_front(); check("araddr", araddr, mon_a); end
            end
            if (awvalid && awready) begin
                if (aw_q.size() == 0) check("aw_spurious", awaddr, 29'h1FFF_FFFF);
                else begin mon_a = aw_q.pop_front(); check("awaddr", awaddr, mon_a); end
            end
            if (wvalid && wready) begin
                if (awvalid && !awready) w_first = 1;
                check("wlast", wlast, 1'b1);
                if (w_q.size() == 0) check("w_spurious", wstrb, 64'h0);
                else begin
                    mon_w = w_q.pop_front();
                    check("wdata", wdata, mon_w.data);
                    check("wstrb", wstrb, mon_w.strb);
                end
            end
            if (bvalid && bready) bhs_cyc = cyc;
            if (ar_stall) check("ar_hold", {arvalid, araddr}, {1'b1, ar_stall_addr});
            if (aw_stall) check("aw_hold", {awvalid, awaddr}, {1'b1, aw_stall_addr});
            if (w_stall) begin
                check("w_hold_valid", wvalid, 1'b1);
                check("w_hold_data", wdata, w_stall_data);
                check("w_hold_strb", wstrb, w_stall_strb);
            end
            ar_stall = arvalid && !arready; ar_stall_addr = araddr;
            aw_stall = awvalid && !awready; aw_stall_addr = awaddr;
            w_stall  = wvalid && !wready;   w_stall_data = wdata; w_stall_strb = wstrb;
        end
    end

    // ---------------- requester drivers ----------------
    task automatic if_txn(input logic [28:0] a, output int n);
        if_addr = a;
        if_req  = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!if_done && n < 60);
        if (!if_done) timeout("if_txn");
        if_req = 1'b0;
    endtask

    task automatic ex_txn(input logic we, input logic [28:0] a, input logic [31:0] d,
                          input logic [3:0] be, output int n);
        ex_we = we; ex_addr = a; ex_wdata = d; ex_wbe = be;
        ex_req = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (!ex_done && n < 60);
        if (!ex_done) timeout("ex_txn");
        ex_req = 1'b0;
    endtask

    task automatic idle(input int c);
        repeat (c) @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected finish");
        $fatal(1, "watchdog");
    end

    int n1, n2, k;

    initial begin : stim
        rstn = 1'b0;
        if_req = 0; if_addr = '0;
        ex_req = 0; ex_we = 0; ex_addr = '0; ex_wdata = '0; ex_wbe = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_arvalid", arvalid, 1'b0);
        check("rst_awvalid", awvalid, 1'b0);
        check("rst_wvalid", wvalid, 1'b0);
        check("rst_rready", rready, 1'b0);
        check("rst_bready", bready, 1'b0);
        check("rst_dones", {if_done, ex_done, resp_err}, 3'b000);
        check("rst_araddr", araddr, 29'h0);
        check("rst_awaddr", awaddr, 29'h0);
        check("rst_wdata", wdata, 512'h0);
        check("rst_wstrb", wstrb, 64'h0);
        check("rst_wlast", wlast, 1'b0);
        check("rst_rdata", {if_rdata, ex_rdata}, 64'h0);
        check("fixed_ar", {arlen, arsize, arburst, arcache, arid, arlock, arprot, arqos},
              {8'd0, 3'b010, 2'b00, 4'b0011, 4'd0, 1'b0, 3'd0, 4'd0});
        check("fixed_aw", {awlen, awsize, awburst, awcache, awid, awlock, awprot, awqos},
              {8'd0, 3'b010, 2'b00, 4'b0011, 4'd0, 1'b0, 3'd0, 4'd0});
        rstn = 1'b1;
        idle(2);

        // fetch read, minimum latency
        exp_done(0, 32'hDEADBEEF, 0, 1);
        ar_q.push_back(29'h44);
        if_txn(29'h44, n1);
        check("fetch_latency", n1, 3);
        idle(2);

        // exec write, awready late, wready immediate
        aw_dly = 3; w_dly = 0; w_first = 0;
        exp_done(1, 32'h0, 0, 0);
        exp_write(29'h3C, {16{32'h12345678}}, 64'hF000_0000_0000_0000);
        ex_txn(1, 29'h3C, 32'h12345678, 4'hF, n1);
        check("w_before_aw", w_first, 1'b1);
        check("done_after_b", cyc - bhs_cyc, 1);
        aw_dly = 0;
        idle(2);

        // exec write with SLVERR
        w_dly = 2; bresp_cfg = 2'b10;
        exp_done(1, 32'h0, 1, 0);
        exp_write(29'h208, {16{32'hCAFEF00D}}, 64'h0000_0000_0000_0300);
        ex_txn(1, 29'h208, 32'hCAFEF00D, 4'b0011, n1);
        check("idle_after_err", dut.state_q, core_axi_pkg::IDLE);
        w_dly = 0; bresp_cfg = 2'b00;
        idle(2);

        // exec read with error response
        rresp_cfg = 2'b10;
        exp_done(1, 32'hB000_007E, 1, 1);
        ar_q.push_back(29'h1F8);
        ex_txn(0, 29'h1F8, 32'h0, 4'h0, n1);
        rresp_cfg = 2'b00;
        idle(2);

        // fetch keeps req high through its done cycle
        exp_done(0, 32'hB000_0004, 0, 1);
        ar_q.push_back(29'h10);
        k = ar_cnt_seen;
        if_addr = 29'h10; if_req = 1'b1; n1 = 0;
        do begin @(posedge clk); #1; n1++; end while (!if_done && n1 < 60);
        if (!if_done) timeout("hold_req");
        @(posedge clk); #1;
        if_req = 1'b0;
        check("hold_no_ar_1", arvalid, 1'b0);
        @(posedge clk); #1;
        check("hold_no_ar_2", arvalid, 1'b0);
        check("hold_ar_count", ar_cnt_seen - k, 1);
        idle(2);

        // simultaneous requests, two rounds: exec first each round
        exp_done(1, 32'hB000_0082, 0, 1);
        exp_done(0, 32'hB000_0040, 0, 1);
        ar_q.push_back(29'h208);
        ar_q.push_back(29'h100);
        fork
            if_txn(29'h100, n1);
            ex_txn(0, 29'h208, 32'h0, 4'h0, n2);
        join
        idle(2);
        exp_done(1, 32'h0, 0, 0);
        exp_done(0, 32'hB000_0003, 0, 1);
        exp_write(29'h40, {16{32'h0BADCAFE}}, 64'h0000_0000_0000_000F);
        ar_q.push_back(29'h0C);
        fork
            if_txn(29'h0C, n1);
            ex_txn(1, 29'h40, 32'h0BADCAFE, 4'hF, n2);
        join
        idle(2);

        // exec served last, then a tie: round-robin hands it to fetch
        exp_done(1, 32'hB000_0020, 0, 1);
        ar_q.push_back(29'h80);
        ex_txn(0, 29'h80, 32'h0, 4'h0, n1);
        idle(2);
`ifdef MEM_ARB_RR_EN
        exp_done(0, 32'hB000_0031, 0, 1);
        exp_done(1, 32'hB000_0041, 0, 1);
        ar_q.push_back(29'hC4);
        ar_q.push_back(29'h104);
`else
        exp_done(1, 32'hB000_0041, 0, 1);
        exp_done(0, 32'hB000_0031, 0, 1);
        ar_q.push_back(29'h104);
        ar_q.push_back(29'hC4);
`endif
        fork
            if_txn(29'hC4, n1);
            ex_txn(0, 29'h104, 32'h0, 4'h0, n2);
        join
        idle(2);

        // reset while waiting for read data
        r_hold = 1;
        ar_q.push_back(29'h300);
        if_addr = 29'h300; if_req = 1'b1; n1 = 0;
        do begin @(posedge clk); #1; n1++; end while (!rready && n1 < 20);
        check("reached_rdata", rready, 1'b1);
        #2 rstn = 1'b0;
        #1;
        check("rst_mid_arvalid", arvalid, 1'b0);
        check("rst_mid_rready", rready, 1'b0);
        check("rst_mid_dones", {if_done, ex_done}, 2'b00);
        if_req = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        r_hold = 0;
        rstn = 1'b1;
        idle(2);
        exp_done(0, 32'hDEADBEEF, 0, 1);
        ar_q.push_back(29'h44);
        if_txn(29'h44, n1);
        check("fetch_after_rst", n1, 3);
        idle(5);

        check("done_q_drained", done_q.size(), 0);
        check("ar_q_drained", ar_q.size(), 0);
        check("aw_q_drained", aw_q.size() + w_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
